// File: rtl/clock_pkg.sv
// Shared types and 50 MHz timing defaults for the
// front-panel button conditioner.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_REPEAT
  } ch_state_e;

  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned DEB_CYCLES_DEF    = 500_000;
  localparam int unsigned REPEAT_DELAY_DEF  = 25_000_000;
  localparam int unsigned REPEAT_PERIOD_DEF = 5_000_000;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One key: 2-flop sync, debounce, and press/auto-repeat
// pulse FSM with an external inhibit.
module button_channel
  import clock_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic butt_n_i,
  input  logic inhibit_i,
  output logic held_o,
  output logic tick_o
);

  localparam int unsigned DW =
    $clog2(DEB_CYCLES + 1);
  localparam int unsigned RW =
    $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [1:0]    sync_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  ch_state_e     state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      dcnt_q  <= '0;
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
    end else begin
      sync_q  <= {sync_q[0], butt_n_i};
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Any sample agreeing with the current level restarts the count.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (dcnt_q == DW'(DEB_CYCLES)) begin
        deb_d = sync_q[1];
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  assign pressed = ~deb_q;
  assign held_o  = pressed;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tick_o  = 1'b0;
    if (!pressed || inhibit_i) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tick_o  = 1'b1;
          state_d = ST_ARMED;
          rcnt_d  = '0;
        end
        ST_ARMED: begin
          if (REPEAT_EN) begin
            if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
              tick_o  = 1'b1;
              state_d = ST_REPEAT;
              rcnt_d  = '0;
            end else if (rcnt_q != '1) begin
              rcnt_d = rcnt_q + RW'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
            tick_o = 1'b1;
            rcnt_d = '0;
          end else if (rcnt_q != '1) begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Three conditioned keys for the decade counter; up and
// down lock each other out while both are pressed.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       butt_increase_n,
  input  logic       butt_decrease_n,
  input  logic       butt_change_n,
  output logic       tick_up,
  output logic       tick_down,
  output logic       tick_change,
  output logic [2:0] held
);

  logic updn_lock;

  assign updn_lock = held[0] & held[1];

  button_channel #(
    .DEB_CYCLES    (DEB_CYCLES),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .REPEAT_EN     (1'b1)
  ) u_inc (
    .clk       (clk),
    .rst_n     (rst_n),
    .butt_n_i  (butt_increase_n),
    .inhibit_i (updn_lock),
    .held_o    (held[0]),
    .tick_o    (tick_up)
  );

  button_channel #(
    .DEB_CYCLES    (DEB_CYCLES),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .REPEAT_EN     (1'b1)
  ) u_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .butt_n_i  (butt_decrease_n),
    .inhibit_i (updn_lock),
    .held_o    (held[1]),
    .tick_o    (tick_down)
  );

  button_channel #(
    .DEB_CYCLES    (DEB_CYCLES),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .REPEAT_EN     (1'b0)
  ) u_chg (
    .clk       (clk),
    .rst_n     (rst_n),
    .butt_n_i  (butt_change_n),
    .inhibit_i (1'b0),
    .held_o    (held[2]),
    .tick_o    (tick_change)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Random and directed key stimulus against a
// window/press-age reference model.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;
  localparam int WIN = DEB + 3;

  logic       clk;
  logic       rst_n;
  logic       butt_increase_n;
  logic       butt_decrease_n;
  logic       butt_change_n;
  logic       tick_up;
  logic       tick_down;
  logic       tick_change;
  logic [2:0] held;

  button_conditioner #(
    .DEB_CYCLES    (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .butt_increase_n (butt_increase_n),
    .butt_decrease_n (butt_decrease_n),
    .butt_change_n   (butt_change_n),
    .tick_up         (tick_up),
    .tick_down       (tick_down),
    .tick_change     (tick_change),
    .held            (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [2:0] raw_v = 3'b111;
  logic       rst_v = 1'b0;

  bit   hq [3][$];
  bit   mp [3];
  int   age[3];
  bit   et [3];

  int up_n, dn_n, ch_n, first_up;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Level flips once the DEB+1 samples that are at least
  // two edges old all disagree with it; pulses follow the
  // age of the accepted press.
  task automatic model_step();
    bit flip;
    bit inh;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        hq[c].delete();
        for (int k = 0; k < WIN; k++) hq[c].push_back(1'b1);
        mp[c]  = 1'b0;
        age[c] = -1;
        et[c]  = 1'b0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        hq[c].push_back(raw_v[c]);
        if (hq[c].size() > WIN) void'(hq[c].pop_front());
        flip = 1'b1;
        for (int k = 0; k <= DEB; k++)
          if ((!hq[c][k]) == mp[c]) flip = 1'b0;
        if (flip) mp[c] = !mp[c];
      end
      inh = mp[0] && mp[1];
      for (int c = 0; c < 3; c++) begin
        if (mp[c] && !(c < 2 && inh))
          age[c] = (age[c] < 0) ? 0 : age[c] + 1;
        else
          age[c] = -1;
        et[c] = (age[c] == 0) ||
                (c < 2 && age[c] >= RD &&
                 ((age[c] - RD) % RP) == 0);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst_n           = rst_v;
    butt_increase_n = raw_v[0];
    butt_decrease_n = raw_v[1];
    butt_change_n   = raw_v[2];
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check("tick_up", 32'(tick_up), 32'(et[0]));
    check("tick_down", 32'(tick_down), 32'(et[1]));
    check("tick_change", 32'(tick_change), 32'(et[2]));
    check("held", 32'(held), 32'({mp[2], mp[1], mp[0]}));
    if (tick_up) begin
      up_n++;
      if (first_up < 0) first_up = cyc;
    end
    if (tick_down) dn_n++;
    if (tick_change) ch_n++;
  endtask

  task automatic clr();
    up_n = 0; dn_n = 0; ch_n = 0; first_up = -1;
  endtask

  task automatic idle(input int n);
    raw_v = 3'b111;
    repeat (n) step();
  endtask

  int t0;
  int dur[3];

  initial begin
    rst_n = 1'b0;
    butt_increase_n = 1'b1;
    butt_decrease_n = 1'b1;
    butt_change_n   = 1'b1;
    clr();
    rst_v = 1'b0;
    repeat (3) step();
    check("reset_held", 32'(held), 32'd0);
    rst_v = 1'b1;
    idle(5);

    // clean increase press, 40 samples low
    clr();
    raw_v[0] = 1'b0;
    t0 = cyc + 1;
    repeat (40) step();
    raw_v[0] = 1'b1;
    repeat (20) step();
    check("s028_count", 32'(up_n), 32'd5);
    check("s028_first", 32'(first_up - t0), 32'd6);

    // bounce then steady low
    idle(10);
    clr();
    raw_v[0] = 1'b0; step();
    raw_v[0] = 1'b1; step();
    raw_v[0] = 1'b0; step();
    raw_v[0] = 1'b1; step();
    raw_v[0] = 1'b0;
    t0 = cyc + 1;
    repeat (15) step();
    check("s029_count", 32'(up_n), 32'd1);
    check("s029_first", 32'(first_up - t0), 32'd6);
    idle(10);

    // change key never repeats
    clr();
    raw_v[2] = 1'b0;
    repeat (100) step();
    raw_v[2] = 1'b1;
    repeat (20) step();
    check("s030_one", 32'(ch_n), 32'd1);
    raw_v[2] = 1'b0;
    repeat (30) step();
    idle(20);
    check("s030_two", 32'(ch_n), 32'd2);

    // up/down interlock
    clr();
    raw_v[0] = 1'b0;
    repeat (15) step();
    raw_v[1] = 1'b0;
    repeat (30) step();
    raw_v[1] = 1'b1;
    repeat (10) step();
    raw_v[0] = 1'b1;
    repeat (20) step();
    check("s031_down", 32'(dn_n), 32'd0);
    check("s031_up", 32'(up_n), 32'd2);

    // reset mid-press
    clr();
    raw_v[0] = 1'b0;
    repeat (30) step();
    rst_v = 1'b0;
    repeat (3) step();
    check("s032_rst", 32'({tick_up, tick_down, tick_change, held}),
          32'd0);
    rst_v = 1'b1;
    clr();
    t0 = cyc + 1;
    repeat (15) step();
    check("s032_first", 32'(first_up - t0), 32'd6);
    check("s032_count", 32'(up_n), 32'd1);
    idle(15);

    // random key activity with rare resets
    for (int c = 0; c < 3; c++) dur[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (dur[c] == 0) begin
          raw_v[c] = 1'($urandom_range(0, 1));
          dur[c] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(1, 3)) :
                   int'($urandom_range(4, 60));
        end
        dur[c]--;
      end
      rst_v = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst_v = 1'b1;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
